// File: rtl/noaa_run_controller.sv
// -----------------------------------------------------------------------------
// noaa_run_controller
//
// Sequencer for the NOAA temperature-statistics datapath. Each run clears the
// sample register file, collects NUM_SAMPLES samples, issues one average
// divide and then up to SD_ITERS sigma refinement divides. Each refinement
// result is fed back as the new sigma estimate. The run ends with a one-cycle
// done pulse. A watchdog on every divide ends the run with a sticky error if
// the divider never answers.
//
// Ports
//   CLK            in   clock, rising edge
//   RESET          in   synchronous, active-high reset
//   i_start        in   request a run (sampled only in IDLE)
//   i_tn_valid     in   sensor sample present this cycle
//   i_div_done     in   divider result valid (single-cycle pulse)
//   i_div_result   in   12-bit quotient, meaningful with i_div_done
//   o_clr          out  clear register file (sum and count)
//   o_sample       out  register file captures TN this cycle
//   o_mode         out  0 = average divide, 1 = standard-deviation divide
//   o_div_start    out  one-cycle divider launch
//   o_sigma_load   out  load i_div_result into sigma_hat
//   o_avg          out  last average (registered)
//   o_sd           out  last standard deviation / sigma estimate (registered)
//   o_busy         out  high in every state except IDLE
//   o_done         out  one-cycle pulse when a run ends
//   o_err          out  sticky divider-timeout flag
// -----------------------------------------------------------------------------
module noaa_run_controller #(
   parameter int unsigned NUM_SAMPLES = 8,   // 1..15
   parameter int unsigned SD_ITERS    = 4,   // 1..15
   parameter int unsigned DIV_TIMEOUT = 64   // 2..255
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        i_start,
   input  logic        i_tn_valid,
   input  logic        i_div_done,
   input  logic [11:0] i_div_result,
   output logic        o_clr,
   output logic        o_sample,
   output logic        o_mode,
   output logic        o_div_start,
   output logic        o_sigma_load,
   output logic [11:0] o_avg,
   output logic [11:0] o_sd,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_err
);

   localparam logic [3:0]  C_NUM_SAMPLES = 4'(NUM_SAMPLES);
   localparam logic [3:0]  C_SD_ITERS    = 4'(SD_ITERS);
   // Last watchdog value before expiry: the wait state spends exactly
   // DIV_TIMEOUT cycles before giving up.
   localparam logic [7:0]  C_WD_LAST     = 8'(DIV_TIMEOUT - 1);
   // Matches the datapath sigma_hat reset value (32 degF).
   localparam logic [11:0] C_SD_INIT     = 12'h400;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_COLLECT,
      S_AVG_ISSUE,
      S_AVG_WAIT,
      S_SD_ISSUE,
      S_SD_WAIT,
      S_FINISH
   } state_t;

   state_t      r_state;
   state_t      w_next_state;

   logic [3:0]  r_count;
   logic [3:0]  r_iter;
   logic [7:0]  r_wd;
   logic [11:0] r_avg;
   logic [11:0] r_sd;
   logic        r_err;

   logic [3:0]  w_count_inc;
   logic [3:0]  w_iter_inc;
   logic        w_wd_expire;
   logic        w_converged;

   assign w_count_inc = r_count + 4'd1;
   assign w_iter_inc  = r_iter + 4'd1;
   assign w_wd_expire = (r_wd == C_WD_LAST);
   // Compared against the pre-update sigma, so a repeated result ends the run.
   assign w_converged = (i_div_result == r_sd);

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking (<=) so every flop samples the
   // pre-edge values of its neighbours regardless of statement order.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state and strobe decode
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // through the case statement leaves one unassigned (no latches).
      w_next_state = r_state;
      o_clr        = 1'b0;
      o_sample     = 1'b0;
      o_mode       = 1'b0;
      o_div_start  = 1'b0;
      o_sigma_load = 1'b0;
      o_done       = 1'b0;
      o_busy       = (r_state != S_IDLE);

      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_next_state = S_CLEAR;
            end
         end

         S_CLEAR: begin
            o_clr        = 1'b1;
            w_next_state = S_COLLECT;
         end

         S_COLLECT: begin
            o_sample = i_tn_valid;
            if (i_tn_valid && (w_count_inc == C_NUM_SAMPLES)) begin
               w_next_state = S_AVG_ISSUE;
            end
         end

         S_AVG_ISSUE: begin
            o_div_start  = 1'b1;
            w_next_state = S_AVG_WAIT;
         end

         S_AVG_WAIT: begin
            // A result arriving in the expiry cycle wins over the timeout.
            if (i_div_done) begin
               w_next_state = S_SD_ISSUE;
            end else if (w_wd_expire) begin
               w_next_state = S_FINISH;
            end
         end

         S_SD_ISSUE: begin
            o_mode       = 1'b1;
            o_div_start  = 1'b1;
            w_next_state = S_SD_WAIT;
         end

         S_SD_WAIT: begin
            o_mode = 1'b1;
            if (i_div_done) begin
               o_sigma_load = 1'b1;
               if (w_converged || (w_iter_inc == C_SD_ITERS)) begin
                  w_next_state = S_FINISH;
               end else begin
                  w_next_state = S_SD_ISSUE;
               end
            end else if (w_wd_expire) begin
               w_next_state = S_FINISH;
            end
         end

         S_FINISH: begin
            o_done       = 1'b1;
            w_next_state = S_IDLE;
         end

         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Counters, results and error flag
   // ---------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_count <= 4'd0;
         r_iter  <= 4'd0;
         r_wd    <= 8'd0;
         r_avg   <= 12'h000;
         r_sd    <= C_SD_INIT;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_err <= 1'b0;
               end
            end

            S_CLEAR: begin
               r_count <= 4'd0;
               r_iter  <= 4'd0;
            end

            S_COLLECT: begin
               if (i_tn_valid) begin
                  r_count <= w_count_inc;
               end
            end

            // Every wait state is entered from its issue state, so zeroing the
            // watchdog here is the same as zeroing it on entry to the wait.
            S_AVG_ISSUE, S_SD_ISSUE: begin
               r_wd <= 8'd0;
            end

            S_AVG_WAIT: begin
               if (i_div_done) begin
                  r_avg <= i_div_result;
               end else if (w_wd_expire) begin
                  r_err <= 1'b1;
               end else begin
                  r_wd <= r_wd + 8'd1;
               end
            end

            S_SD_WAIT: begin
               if (i_div_done) begin
                  r_sd   <= i_div_result;
                  r_iter <= w_iter_inc;
               end else if (w_wd_expire) begin
                  r_err <= 1'b1;
               end else begin
                  r_wd <= r_wd + 8'd1;
               end
            end

            default: begin
            end
         endcase
      end
   end

   assign o_avg = r_avg;
   assign o_sd  = r_sd;
   assign o_err = r_err;

endmodule

// File: tb/tb_noaa_run_controller.sv
// -----------------------------------------------------------------------------
// tb_noaa_run_controller
//
// Directed bench for noaa_run_controller with default parameters
// (NUM_SAMPLES=8, SD_ITERS=4, DIV_TIMEOUT=64). A small divider model answers
// each launch after a configurable latency (default 2) with the next value
// from a result queue; an empty queue models a hung divider. Cycle numbers
// count from the edge that samples START (cycle 1 = first cycle after it).
// -----------------------------------------------------------------------------
module tb_noaa_run_controller;

   logic        CLK;
   logic        RESET;
   logic        start;
   logic        tn_valid;
   logic        r_done;     // divider model
   logic [11:0] r_res;
   logic        m_done;     // manual injection from the main sequence
   logic [11:0] m_res;
   logic        div_done;
   logic [11:0] div_result;

   logic        clr, sample, mode, div_start, sigma_load, busy, done, err;
   logic [11:0] avg, sd;

   assign div_done   = r_done | m_done;
   assign div_result = m_done ? m_res : r_res;

   noaa_run_controller dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .i_start      (start),
      .i_tn_valid   (tn_valid),
      .i_div_done   (div_done),
      .i_div_result (div_result),
      .o_clr        (clr),
      .o_sample     (sample),
      .o_mode       (mode),
      .o_div_start  (div_start),
      .o_sigma_load (sigma_load),
      .o_avg        (avg),
      .o_sd         (sd),
      .o_busy       (busy),
      .o_done       (done),
      .o_err        (err)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   int checks = 0;
   int errors = 0;

   logic [11:0] res_q[$];
   int          lat_q[$];

   // Per-run observations
   int          n_sample, n_clr, n_ds, n_sl;
   int          done_cyc, first_ds_cyc, last_sample_cyc, bad_sample;
   logic [7:0]  mode_log;
   logic        err_c1, busy_at_done, err_at_done;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Divider model: answers a launch after the next queued latency (default 2)
   // with the next queued result, and checks MODE was held over the divide.
   initial begin : divider_model
      int         lat;
      logic       launch_mode;
      logic [11:0] v;
      r_done = 1'b0;
      r_res  = 12'h000;
      forever begin
         @(negedge CLK);
         if (div_start === 1'b1 && res_q.size() > 0) begin
            lat         = (lat_q.size() > 0) ? lat_q.pop_front() : 2;
            launch_mode = mode;
            v           = res_q.pop_front();
            repeat (lat) @(posedge CLK);
            #1;
            r_done = 1'b1;
            r_res  = v;
            @(negedge CLK);
            check("mode_held_at_done", {31'd0, mode}, {31'd0, launch_mode});
            check("sigma_load_at_done", {31'd0, sigma_load}, {31'd0, launch_mode});
            @(posedge CLK);
            #1;
            r_done = 1'b0;
         end
      end
   end

   // Pulse START in IDLE, then observe the run until DONE (bounded).
   task automatic run_and_wait(input bit gapped);
      n_sample = 0; n_clr = 0; n_ds = 0; n_sl = 0;
      done_cyc = -1; first_ds_cyc = -1; last_sample_cyc = -1; bad_sample = 0;
      mode_log = 8'd0; err_c1 = 1'b0; busy_at_done = 1'b0; err_at_done = 1'b0;
      @(posedge CLK);
      #1 start = 1'b1;
      @(posedge CLK);
      #1 start = 1'b0;
      tn_valid = 1'b1;
      for (int c = 1; c <= 400; c++) begin
         @(negedge CLK);
         if (sample) begin
            n_sample++;
            last_sample_cyc = c;
            if (!tn_valid) bad_sample++;
         end
         if (clr) n_clr++;
         if (div_start) begin
            n_ds++;
            mode_log = {mode_log[6:0], mode};
            if (first_ds_cyc < 0) first_ds_cyc = c;
         end
         if (sigma_load) n_sl++;
         if (c == 1) err_c1 = err;
         if (done) begin
            done_cyc     = c;
            busy_at_done = busy;
            err_at_done  = err;
            break;
         end
         @(posedge CLK);
         #1 tn_valid = gapped ? 1'((c + 1) % 2) : 1'b1;
      end
      check("run_reached_done", {31'd0, done_cyc >= 0}, 32'd1);
   endtask

   initial begin : main_seq
      bit found;
      RESET    = 1'b1;
      start    = 1'b0;
      tn_valid = 1'b1;
      m_done   = 1'b0;
      m_res    = 12'h000;

      // ---- Reset values --------------------------------------------------
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      check("rst_clr",        {31'd0, clr},        32'd0);
      check("rst_sample",     {31'd0, sample},     32'd0);
      check("rst_mode",       {31'd0, mode},       32'd0);
      check("rst_div_start",  {31'd0, div_start},  32'd0);
      check("rst_sigma_load", {31'd0, sigma_load}, 32'd0);
      check("rst_busy",       {31'd0, busy},       32'd0);
      check("rst_done",       {31'd0, done},       32'd0);
      check("rst_err",        {31'd0, err},        32'd0);
      check("rst_avg",        {20'd0, avg},        32'h000);
      check("rst_sd",         {20'd0, sd},         32'h400);
      @(posedge CLK);
      #1 RESET = 1'b0;

      // ---- Full run, no convergence --------------------------------------
      res_q = '{12'h200, 12'h050, 12'h049, 12'h048, 12'h047};
      run_and_wait(1'b0);
      check("full_done_cycle",  done_cyc,     25);
      check("full_clr",         n_clr,        1);
      check("full_samples",     n_sample,     8);
      check("full_last_sample", last_sample_cyc, 9);
      check("full_div_starts",  n_ds,         5);
      check("full_sigma_loads", n_sl,         4);
      check("full_mode_log",    {24'd0, mode_log}, 32'h0F);
      check("full_busy_done",   {31'd0, busy_at_done}, 32'd1);
      check("full_avg",         {20'd0, avg}, 32'h200);
      check("full_sd",          {20'd0, sd},  32'h047);
      check("full_err",         {31'd0, err_at_done}, 32'd0);
      @(negedge CLK);
      check("full_idle_busy",   {31'd0, busy}, 32'd0);
      check("full_idle_done",   {31'd0, done}, 32'd0);

      // ---- Early convergence (sigma starts at 0x047) ---------------------
      res_q = '{12'h180, 12'h060, 12'h058, 12'h058};
      run_and_wait(1'b0);
      check("conv_done_cycle",  done_cyc,     22);
      check("conv_div_starts",  n_ds,         4);
      check("conv_sigma_loads", n_sl,         3);
      check("conv_mode_log",    {24'd0, mode_log}, 32'h07);
      check("conv_avg",         {20'd0, avg}, 32'h180);
      check("conv_sd",          {20'd0, sd},  32'h058);

      // ---- Gapped samples; sigma already 0x058 so one iteration ----------
      res_q = '{12'h0F0, 12'h058};
      run_and_wait(1'b1);
      check("gap_samples",      n_sample,        8);
      check("gap_sample_valid", bad_sample,      0);
      check("gap_last_sample",  last_sample_cyc, 17);
      check("gap_first_ds",     first_ds_cyc,    18);
      check("gap_done_cycle",   done_cyc,        24);
      check("gap_sigma_loads",  n_sl,            1);
      check("gap_avg",          {20'd0, avg},    32'h0F0);
      check("gap_sd",           {20'd0, sd},     32'h058);

      // ---- Divider hang in AVG_WAIT ---------------------------------------
      res_q.delete();
      run_and_wait(1'b0);
      check("hang_first_ds",    first_ds_cyc, 10);
      check("hang_done_cycle",  done_cyc,     75);
      check("hang_ds_to_done",  done_cyc - first_ds_cyc, 65);
      check("hang_err",         {31'd0, err_at_done}, 32'd1);
      check("hang_sigma_loads", n_sl,         0);
      check("hang_avg",         {20'd0, avg}, 32'h0F0);
      check("hang_sd",          {20'd0, sd},  32'h058);
      @(negedge CLK);
      check("hang_err_sticky",  {31'd0, err}, 32'd1);

      // ---- Next START clears ERR; DIV_DONE in the expiry cycle accepted ---
      lat_q = '{64};
      res_q = '{12'h111, 12'h058};
      run_and_wait(1'b0);
      check("edge_err_cleared", {31'd0, err_c1},      32'd0);
      check("edge_done_cycle",  done_cyc,             78);
      check("edge_err",         {31'd0, err_at_done}, 32'd0);
      check("edge_avg",         {20'd0, avg},         32'h111);
      check("edge_sd",          {20'd0, sd},          32'h058);

      // ---- Reset during SD_WAIT, then a stale DIV_DONE --------------------
      res_q = '{12'h222};
      @(posedge CLK);
      #1 start = 1'b1;
      @(posedge CLK);
      #1 start = 1'b0;
      found = 1'b0;
      for (int c = 1; c <= 100; c++) begin
         @(negedge CLK);
         if (div_start && mode) begin
            found = 1'b1;
            break;
         end
      end
      check("rstmid_sd_issue_seen", {31'd0, found}, 32'd1);
      @(posedge CLK);
      #1 RESET = 1'b1;
      @(posedge CLK);
      #1 RESET = 1'b0;
      m_done = 1'b1;
      m_res  = 12'h123;
      @(negedge CLK);
      check("rstmid_sigma_load", {31'd0, sigma_load}, 32'd0);
      check("rstmid_busy",       {31'd0, busy},       32'd0);
      @(posedge CLK);
      #1 m_done = 1'b0;
      @(negedge CLK);
      check("rstmid_sd",   {20'd0, sd},   32'h400);
      check("rstmid_avg",  {20'd0, avg},  32'h000);
      check("rstmid_busy_after", {31'd0, busy}, 32'd0);
      check("rstmid_err",  {31'd0, err},  32'd0);
      check("rstmid_done", {31'd0, done}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/noaa_run_controller.md
# noaa_run_controller

Sequencer for the NOAA temperature-statistics datapath. On each `START` it runs one full measurement and reports the result:
- clears the sample register file, then collects `NUM_SAMPLES` temperature samples;
- launches one average divide (`MODE=0`), then up to `SD_ITERS` standard-deviation refinement divides (`MODE=1`), feeding each result back as the new sigma estimate;
- reports `AVG`/`SD` with a one-cycle `DONE`.

It owns every control strobe of the datapath: sample capture, mode select, divider launch and sigma load. A divider watchdog flags hung divides.

## Interface
Parameters:
- `NUM_SAMPLES`, default 8, samples per run; legal range 1..15.
- `SD_ITERS`, default 4, maximum sigma refinement divides per run; legal range 1..15.
- `DIV_TIMEOUT`, default 64, cycles to wait for `DIV_DONE` before flagging an error; legal range 2..255.

Ports:
- `CLK`  in  1  clock; all logic on the rising edge.
- `RESET`  in  1  reset, synchronous, active-high.
- `START`  in  1  request a run; sampled only in IDLE.
- `TN_VALID`  in  1  sensor sample present this cycle.
- `DIV_DONE`  in  1  divider result valid, single-cycle pulse.
- `DIV_RESULT`  in  12  quotient; meaningful only when `DIV_DONE=1`.
- `CLR`  out  1  clears the register file (sum and count).
- `SAMPLE`  out  1  register file captures `TN` this cycle.
- `MODE`  out  1  0 = average, 1 = standard deviation; held stable while a divide is outstanding.
- `DIV_START`  out  1  one-cycle divider launch.
- `SIGMA_LOAD`  out  1  load `DIV_RESULT` into sigma_hat.
- `AVG`  out  12  last average, registered.
- `SD`  out  12  last standard deviation / sigma estimate, registered.
- `BUSY`  out  1  high in every state except IDLE.
- `DONE`  out  1  one-cycle pulse when a run ends.
- `ERR`  out  1  sticky divider-timeout flag.

## Operation
States: IDLE, CLEAR, COLLECT, AVG_ISSUE, AVG_WAIT, SD_ISSUE, SD_WAIT, FINISH.

Transitions:
- **IDLE:** `START=1` → CLEAR. `ERR` is cleared on this transition. `START` in any other state is ignored.
- **CLEAR:** `CLR=1` for exactly one cycle. Sample count and iteration count are zeroed. → COLLECT.
- **COLLECT:**
  - `SAMPLE = TN_VALID`, combinational from state.
  - Each cycle with `TN_VALID=1` increments the 4-bit sample count.
  - The accept that makes count equal `NUM_SAMPLES` → AVG_ISSUE.
  - `TN_VALID=0` stalls COLLECT indefinitely; there is no timeout.
- **AVG_ISSUE:** `DIV_START=1`, `MODE=0`, one cycle. → AVG_WAIT.
- **AVG_WAIT:** `MODE=0`. On `DIV_DONE`: `AVG<=DIV_RESULT` → SD_ISSUE.
- **SD_ISSUE:** `DIV_START=1`, `MODE=1`, one cycle. → SD_WAIT.
- **SD_WAIT:** `MODE=1`. On `DIV_DONE`:
  - `SD<=DIV_RESULT`, `SIGMA_LOAD=1` in the same cycle, iteration count +1.
  - If `DIV_RESULT == SD` (the pre-update value, i.e. converged) or the new iteration count equals `SD_ITERS` → FINISH.
  - Otherwise → SD_ISSUE.
- **FINISH:** `DONE=1` for one cycle. → IDLE.

Watchdog:
- An 8-bit counter is zeroed on entry to AVG_WAIT or SD_WAIT and increments each wait cycle without `DIV_DONE`.
- Reaching `DIV_TIMEOUT` sets `ERR=1` and → FINISH. `AVG` and `SD` are not updated.

Other rules:
- `DIV_DONE` outside the WAIT states is ignored.
- `DIV_DONE` in the same cycle the watchdog expires: the result is accepted and no error is flagged.
- `SD` is initialised to 0x400 (32 °F), matching the datapath sigma_hat reset. The first convergence compare uses 0x400.
- `SD` and `AVG` persist across runs. `SD` is not reset by `START`, so each run's refinement starts from the previous sigma.

## Timing
- Reset values: state IDLE; `CLR=SAMPLE=MODE=DIV_START=SIGMA_LOAD=BUSY=DONE=ERR=0`; `AVG=0x000`; `SD=0x400`; all counters 0.
- `RESET` mid-run forces all of the above on the next edge. An outstanding divide is abandoned and a later `DIV_DONE` is ignored.
- `CLR`, `DIV_START`, `DONE` and `BUSY` are decoded from the state register. `SAMPLE` and `SIGMA_LOAD` additionally AND in `TN_VALID` / `DIV_DONE`.
- Latency from the `START` sample edge, assuming `TN_VALID` held high and divider latency L (`DIV_DONE` L cycles after `DIV_START`):
  - `DONE` is asserted at cycle `2 + NUM_SAMPLES + (L+1)·(1 + k)`, where k is the number of SD iterations performed.
- `START` held high during a run has no effect. If `START` is still high in the IDLE cycle after FINISH, a new run begins.

## Test plan
- **Reset values:** Assert `RESET` 2 cycles → all outputs at reset values; `SD=0x400`; `BUSY=0`.
- **Full run, no convergence:** `NUM_SAMPLES=8`, `SD_ITERS=4`, `TN_VALID=1`, divider L=2; results 0x200, then 0x050, 0x049, 0x048, 0x047 → exactly 8 `SAMPLE` pulses, 5 `DIV_START` pulses, 4 `SIGMA_LOAD` pulses; `AVG=0x200`, `SD=0x047`; `DONE` at cycle 25.
- **Early convergence:** SD results 0x060, 0x058, 0x058 → FINISH after 3 iterations, `SD=0x058`, `DONE` at cycle 22 (L=2).
- **Gapped samples:** `TN_VALID` high every other cycle → `SAMPLE` follows `TN_VALID`; COLLECT lasts 16 cycles for 8 samples; no extra counts.
- **Divider hang:** `DIV_DONE` never returned in AVG_WAIT with `DIV_TIMEOUT=64` → `ERR=1` and `DONE` 65 cycles after `DIV_START`; `AVG` unchanged. The next `START` clears `ERR`.
- **Reset mid-run:** Pulse `RESET` during SD_WAIT, then inject `DIV_DONE` with 0x123 → no `SIGMA_LOAD`, `SD=0x400`, state IDLE.
